// File: rtl/csr_row_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : csr_row_sequencer_if
//  Brief    : Row-pointer input and element-index output bundle for the
//             CSR row sequencer. slave = sequencer view, master = driver view.
//  Revision : 1.0  initial release
// ============================================================================
interface csr_row_sequencer_if #(
    parameter int IDX_W = 32,
    parameter int ROW_W = 32
);
    logic             ptr_valid;
    logic             ptr_ready;
    logic [IDX_W-1:0] ptr_data;
    logic             elem_valid;
    logic             elem_ready;
    logic [IDX_W-1:0] elem_idx;
    logic [ROW_W-1:0] elem_row;
    logic             elem_last;
    logic             elem_empty;
    logic [IDX_W-1:0] row_len;
    logic             row_start;
    logic             row_done;
    logic             err_neg;

    modport slave (
        input  ptr_valid, ptr_data, elem_ready,
        output ptr_ready, elem_valid, elem_idx, elem_row, elem_last,
               elem_empty, row_len, row_start, row_done, err_neg
    );

    modport master (
        output ptr_valid, ptr_data, elem_ready,
        input  ptr_ready, elem_valid, elem_idx, elem_row, elem_last,
               elem_empty, row_len, row_start, row_done, err_neg
    );
endinterface
`default_nettype wire

// File: rtl/csr_row_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : csr_row_sequencer
//  Brief    : Expands the CSR row-pointer stream into per-row nonzero element
//             indices with row tag, last flag, row_start/row_done pulses.
//             Optional: CSR_EMPTY_ROW_MARKER_EN emits one marker beat per
//             empty row.
//  Revision : 1.0  initial release
// ============================================================================
module csr_row_sequencer #(
    parameter int IDX_W = 32,
    parameter int ROW_W = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clear,
    csr_row_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {
        S_PRIME = 2'd0,
        S_WAIT  = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] c_idx_one = IDX_W'(1);
    localparam logic [ROW_W-1:0] c_row_one = ROW_W'(1);

    state_t           r_state,      w_state_nxt;
    logic [ROW_W-1:0] r_row,        w_row_nxt;
    logic [IDX_W-1:0] r_prev_ptr,   w_prev_ptr_nxt;
    logic [IDX_W-1:0] r_remaining,  w_remaining_nxt;
    logic [IDX_W-1:0] r_elem_idx,   w_elem_idx_nxt;
    logic [IDX_W-1:0] r_row_len,    w_row_len_nxt;
    logic             r_elem_valid, w_elem_valid_nxt;
    logic             r_row_start,  w_row_start_nxt;
    logic             r_row_done,   w_row_done_nxt;
    logic             r_err_neg,    w_err_neg_nxt;
`ifdef CSR_EMPTY_ROW_MARKER_EN
    logic             r_elem_empty, w_elem_empty_nxt;
`endif

    logic             w_ptr_ready;
    logic             w_ptr_hs;
    logic             w_elem_hs;
    logic             w_neg;
    logic [IDX_W-1:0] w_len;

    assign w_ptr_ready = (r_state != S_EMIT);
    assign w_ptr_hs    = bus.ptr_valid && w_ptr_ready;
    assign w_elem_hs   = r_elem_valid && bus.elem_ready;
    // A decreasing pointer is flagged and the row is treated as empty.
    assign w_neg       = (bus.ptr_data < r_prev_ptr);
    assign w_len       = w_neg ? '0 : (bus.ptr_data - r_prev_ptr);

    always_comb begin
        w_state_nxt      = r_state;
        w_row_nxt        = r_row;
        w_prev_ptr_nxt   = r_prev_ptr;
        w_remaining_nxt  = r_remaining;
        w_elem_idx_nxt   = r_elem_idx;
        w_row_len_nxt    = r_row_len;
        w_elem_valid_nxt = r_elem_valid;
        w_row_start_nxt  = 1'b0;
        w_row_done_nxt   = 1'b0;
        w_err_neg_nxt    = r_err_neg;
`ifdef CSR_EMPTY_ROW_MARKER_EN
        w_elem_empty_nxt = r_elem_empty;
`endif
        case (r_state)
            S_PRIME: begin
                if (w_ptr_hs) begin
                    w_prev_ptr_nxt = bus.ptr_data;
                    w_state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_ptr_hs) begin
                    w_prev_ptr_nxt  = bus.ptr_data;
                    w_row_len_nxt   = w_len;
                    w_row_start_nxt = 1'b1;
                    w_err_neg_nxt   = r_err_neg | w_neg;
                    if (w_len != '0) begin
                        w_state_nxt      = S_EMIT;
                        w_elem_valid_nxt = 1'b1;
                        w_elem_idx_nxt   = r_prev_ptr;
                        w_remaining_nxt  = w_len;
                    end else begin
`ifdef CSR_EMPTY_ROW_MARKER_EN
                        w_state_nxt      = S_EMIT;
                        w_elem_valid_nxt = 1'b1;
                        w_elem_empty_nxt = 1'b1;
                        w_elem_idx_nxt   = r_prev_ptr;
                        w_remaining_nxt  = c_idx_one;
`else
                        w_row_done_nxt   = 1'b1;
                        w_row_nxt        = r_row + c_row_one;
`endif
                    end
                end
            end
            S_EMIT: begin
                if (w_elem_hs) begin
                    w_elem_idx_nxt  = r_elem_idx + c_idx_one;
                    w_remaining_nxt = r_remaining - c_idx_one;
                    if (r_remaining == c_idx_one) begin
                        w_elem_valid_nxt = 1'b0;
                        w_row_done_nxt   = 1'b1;
                        w_row_nxt        = r_row + c_row_one;
                        w_state_nxt      = S_WAIT;
`ifdef CSR_EMPTY_ROW_MARKER_EN
                        w_elem_empty_nxt = 1'b0;
`endif
                    end
                end
            end
            default: w_state_nxt = S_PRIME;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            r_state      <= S_PRIME;
            r_row        <= '0;
            r_prev_ptr   <= '0;
            r_remaining  <= '0;
            r_elem_idx   <= '0;
            r_row_len    <= '0;
            r_elem_valid <= 1'b0;
            r_row_start  <= 1'b0;
            r_row_done   <= 1'b0;
            r_err_neg    <= 1'b0;
`ifdef CSR_EMPTY_ROW_MARKER_EN
            r_elem_empty <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_prev_ptr   <= w_prev_ptr_nxt;
            r_remaining  <= w_remaining_nxt;
            r_elem_idx   <= w_elem_idx_nxt;
            r_row_len    <= w_row_len_nxt;
            r_elem_valid <= w_elem_valid_nxt;
            r_row_start  <= w_row_start_nxt;
            r_row_done   <= w_row_done_nxt;
            r_err_neg    <= w_err_neg_nxt;
`ifdef CSR_EMPTY_ROW_MARKER_EN
            r_elem_empty <= w_elem_empty_nxt;
`endif
        end
    end

    assign bus.ptr_ready  = w_ptr_ready;
    assign bus.elem_valid = r_elem_valid;
    assign bus.elem_idx   = r_elem_idx;
    assign bus.elem_row   = r_row;
    assign bus.elem_last  = (r_remaining == c_idx_one);
    assign bus.row_len    = r_row_len;
    assign bus.row_start  = r_row_start;
    assign bus.row_done   = r_row_done;
    assign bus.err_neg    = r_err_neg;
`ifdef CSR_EMPTY_ROW_MARKER_EN
    assign bus.elem_empty = r_elem_empty;
`else
    assign bus.elem_empty = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csr_row_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_row_sequencer
//  Brief    : Directed and random row-pointer streams checked against a
//             pointer-difference model of the expected element beats.
//  Revision : 1.0  initial release
// ============================================================================
module tb_csr_row_sequencer;
    localparam int IDX_W = 32;
    localparam int ROW_W = 2;
`ifdef CSR_EMPTY_ROW_MARKER_EN
    localparam int c_mark = 1;
`else
    localparam int c_mark = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic clear;
    always #5 clk = ~clk;

    csr_row_sequencer_if #(.IDX_W(IDX_W), .ROW_W(ROW_W)) bus ();
    csr_row_sequencer #(.IDX_W(IDX_W), .ROW_W(ROW_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: row counter, last pointer, sticky error
    bit          m_primed;
    logic [31:0] m_prev;
    int          m_row;
    bit          m_err;
    int          rdy_mode;
    int          tgl;
    int          miss;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_primed = 0;
        m_prev   = '0;
        m_row    = 0;
        m_err    = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 64'(bus.elem_valid), 64'd0);
        chk({tag, "_last"},  64'(bus.elem_last),  64'd0);
        chk({tag, "_empty"}, 64'(bus.elem_empty), 64'd0);
        chk({tag, "_start"}, 64'(bus.row_start),  64'd0);
        chk({tag, "_done"},  64'(bus.row_done),   64'd0);
        chk({tag, "_err"},   64'(bus.err_neg),    64'd0);
        chk({tag, "_idx"},   64'(bus.elem_idx),   64'd0);
        chk({tag, "_row"},   64'(bus.elem_row),   64'd0);
        chk({tag, "_len"},   64'(bus.row_len),    64'd0);
        chk({tag, "_pready"},64'(bus.ptr_ready),  64'd1);
    endtask

    task automatic pick_ready(output logic r);
        case (rdy_mode)
            1: begin r = ((tgl % 3) == 0); tgl++; end
            2: begin
                r = ($urandom_range(0, 3) != 0) || (miss >= 2);
                if (r) miss = 0; else miss++;
            end
            default: r = 1'b1;
        endcase
    endtask

    // Called at a negedge; returns at the negedge where row_done is expected.
    task automatic push_ptr(input logic [31:0] v);
        logic [31:0] len;
        bit          neg;
        int          nbeats;
        bit          emp;
        logic        r;
        chk("ptr_ready_idle", 64'(bus.ptr_ready), 64'd1);
        bus.ptr_valid = 1'b1;
        bus.ptr_data  = v;
        @(negedge clk);
        bus.ptr_valid = 1'b0;
        bus.ptr_data  = $urandom;
        if (!m_primed) begin
            m_primed = 1;
            m_prev   = v;
            chk("prime_start", 64'(bus.row_start),  64'd0);
            chk("prime_valid", 64'(bus.elem_valid), 64'd0);
            return;
        end
        neg = (v < m_prev);
        if (neg) m_err = 1;
        len    = neg ? 32'd0 : (v - m_prev);
        emp    = (len == 0);
        nbeats = emp ? c_mark : int'(len);
        chk("row_start", 64'(bus.row_start), 64'd1);
        chk("row_len",   64'(bus.row_len),   64'(len));
        chk("err_neg",   64'(bus.err_neg),   64'(m_err));
        for (int j = 0; j < nbeats; j++) begin
            forever begin
                chk("beat_valid", 64'(bus.elem_valid), 64'd1);
                chk("beat_idx",   64'(bus.elem_idx),   64'(m_prev + 32'(j)));
                chk("beat_row",   64'(bus.elem_row),   64'(m_row));
                chk("beat_last",  64'(bus.elem_last),  64'(j == nbeats - 1));
                chk("beat_empty", 64'(bus.elem_empty), 64'(emp));
                chk("beat_pready",64'(bus.ptr_ready),  64'd0);
                chk("beat_done",  64'(bus.row_done),   64'd0);
                pick_ready(r);
                bus.elem_ready = r;
                @(negedge clk);
                if (r) break;
            end
        end
        chk("done_pulse", 64'(bus.row_done),   64'd1);
        chk("done_valid", 64'(bus.elem_valid), 64'd0);
        chk("done_last",  64'(bus.elem_last),  64'd0);
        if (nbeats > 0)
            chk("done_nostart", 64'(bus.row_start), 64'd0);
        m_row  = (m_row + 1) % (1 << ROW_W);
        m_prev = v;
        chk("done_row", 64'(bus.elem_row), 64'(m_row));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk_reset_vals("clear");
        model_reset();
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1;
        clear = 1'b0;
        bus.ptr_valid = 1'b0;
        bus.ptr_data = '0;
        bus.elem_ready = 1'b1;
        rdy_mode = 0; tgl = 0; miss = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("post_rst");

        // Single row of three
        push_ptr(32'd0); push_ptr(32'd3);

        // Non-empty, empty, non-empty rows
        do_clear();
        push_ptr(32'd0); push_ptr(32'd2); push_ptr(32'd2); push_ptr(32'd5);

        // Backpressure 1,0,0 pattern
        do_clear();
        rdy_mode = 1; tgl = 0;
        push_ptr(32'd4); push_ptr(32'd7);
        rdy_mode = 0;

        // Decreasing pointer: sticky error, empty row, recovery
        do_clear();
        push_ptr(32'd5); push_ptr(32'd3); push_ptr(32'd6);
        chk("err_sticky", 64'(bus.err_neg), 64'd1);

        // Asynchronous reset in the middle of a row
        do_clear();
        push_ptr(32'd0);
        bus.ptr_valid = 1'b1; bus.ptr_data = 32'd4; bus.elem_ready = 1'b1;
        @(negedge clk);
        bus.ptr_valid = 1'b0;
        chk("mid_idx0", 64'(bus.elem_idx), 64'd0);
        @(negedge clk);
        chk("mid_idx1", 64'(bus.elem_idx), 64'd1);
        @(negedge clk);
        chk("mid_idx2", 64'(bus.elem_idx), 64'd2);
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        push_ptr(32'd10); push_ptr(32'd12);

        // Row counter wrap with two-bit row field
        do_clear();
        for (int i = 0; i < 6; i++) push_ptr(32'(i));

        // Random pointer streams with random backpressure and idle gaps
        do_clear();
        rdy_mode = 2;
        push_ptr(32'($urandom_range(0, 1000)));
        for (int i = 0; i < 40; i++) begin
            if (($urandom_range(0, 7) == 0) && (m_prev >= 32'd3))
                v = m_prev - 32'($urandom_range(1, 3));
            else
                v = m_prev + 32'($urandom_range(0, 6));
            push_ptr(v);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("idle_done",   64'(bus.row_done),  64'd0);
                chk("idle_pready", 64'(bus.ptr_ready), 64'd1);
                chk("idle_err",    64'(bus.err_neg),   64'(m_err));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
